// File: rtl/and_vector_stepper.sv
// rtl/and_vector_stepper.sv - stimulus/check stepper for the two-AND gate stage
//
// Drives {a,b,c} through all eight codes, holds each for HOLD_CYCLES, then
// compares the returned d_in/e_in against d=a&b, e=a&b&c.
// Optional macro: STEPPER_GRAY_EN selects Gray sweep order 0,1,3,2,6,7,5,4
// (one input toggles per step); otherwise the sweep is binary 0..7.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   start    - run request, sampled only in IDLE
//   a, b, c  - vector to the gate stage, a is the MSB of the code
//   d_in     - d returned from the gate stage
//   e_in     - e returned from the gate stage
//   busy     - high while sweeping
//   done     - one-cycle pulse at end of run
//   vec      - step index 0..7 within the current sweep
//   err_cnt  - mismatching vectors this run, saturating at 15
//   pass     - err_cnt==0 at end of run, held until next start
module and_vector_stepper #(
  parameter int HOLD_CYCLES = 2,
  parameter int PASSES      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       d_in,
  input  logic       e_in,
  output logic       busy,
  output logic       done,
  output logic [2:0] vec,
  output logic [3:0] err_cnt,
  output logic       pass
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [1:0] PASS_LAST = 2'(PASSES - 1);

  state_t     state;
  logic [3:0] hold_cnt;
  logic [1:0] pass_cnt;
  logic       mismatch;
  logic [3:0] err_next;

  // Step index to driven code.
  function automatic logic [2:0] vec_code(input logic [2:0] v);
`ifdef STEPPER_GRAY_EN
    vec_code = v ^ {1'b0, v[2:1]};
`else
    vec_code = v;
`endif
  endfunction

  // Compare uses the registered drive values, so the expected response is
  // always tied to exactly what the gate stage is currently seeing.
  always_comb begin
    mismatch = (d_in != (a & b)) || (e_in != (a & b & c));
    err_next = err_cnt;
    if (mismatch && (err_cnt != 4'd15)) begin
      err_next = err_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pass_cnt <= '0;
      vec      <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      c        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cnt  <= '0;
      pass     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= DRIVE;
            vec         <= '0;
            pass_cnt    <= '0;
            err_cnt     <= '0;
            pass        <= 1'b0;
            hold_cnt    <= HOLD_LOAD;
            busy        <= 1'b1;
            {a, b, c}   <= vec_code(3'd0);
          end
        end
        DRIVE: begin
          if (hold_cnt == 4'd0) begin
            state <= SAMPLE;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          err_cnt  <= err_next;
          hold_cnt <= HOLD_LOAD;
          if (vec != 3'd7) begin
            vec       <= vec + 3'd1;
            {a, b, c} <= vec_code(vec + 3'd1);
            state     <= DRIVE;
          end else if (pass_cnt < PASS_LAST) begin
            vec       <= '0;
            pass_cnt  <= pass_cnt + 2'd1;
            {a, b, c} <= vec_code(3'd0);
            state     <= DRIVE;
          end else begin
            // err_next includes this final compare.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 4'd0);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
